// File: rtl/home_pkg.sv
// Shared types and constants for the smart-home tank controller blocks.
package home_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REST  = 3'd1,
        ARMED = 3'd2,
        FILL  = 3'd3,
        FAULT = 3'd4
    } pump_state_t;

    localparam logic [1:0] FLT_NONE     = 2'b00;
    localparam logic [1:0] FLT_DRYRUN   = 2'b01;
    localparam logic [1:0] FLT_CONFLICT = 2'b10;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/pump_sequencer_if.sv
// Sensor/motor/status bundle between the tank sensors, the pump sequencer and the home status logic.
interface pump_sequencer_if;

    logic       ennt;
    logic       lowll;
    logic       highll;
    logic       fault_clr;
    logic       moton;
    logic       fault;
    logic [1:0] fault_code;
    logic [7:0] fills_done;

    modport master (
        output ennt, lowll, highll, fault_clr,
        input  moton, fault, fault_code, fills_done
    );

    modport slave (
        input  ennt, lowll, highll, fault_clr,
        output moton, fault, fault_code, fills_done
    );

endinterface

// File: rtl/pump_timer.sv
// Loadable down-counter shared by the lockout and on-time phases; expired when it reaches zero.
module pump_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] load_val,
    output logic             expired
);

    logic [WIDTH-1:0] count_r;

    // Counter register: load has priority, then decrement while enabled and non-zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {WIDTH{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (en && (count_r != {WIDTH{1'b0}})) begin
            count_r <= count_r - WIDTH'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = (count_r == {WIDTH{1'b0}});

endmodule

// File: rtl/pump_sequencer.sv
// Water-tank pump sequencer: lockout between runs, dry-run timeout, sensor-conflict fault, fill counter.
module pump_sequencer
    import home_pkg::*;
#(
    parameter int MIN_OFF_CYC = 8,
    parameter int MAX_ON_CYC  = 64
) (
    input  logic              clk,
    input  logic              rst,
    pump_sequencer_if.slave   bus
);

    localparam int MAX_CYC = (MIN_OFF_CYC > MAX_ON_CYC) ? MIN_OFF_CYC : MAX_ON_CYC;
    localparam int TW      = $clog2(MAX_CYC + 1);
    // Timer expires on the cycle after it reaches zero, so load one less than the phase length.
    localparam logic [TW-1:0] REST_LOAD = TW'(MIN_OFF_CYC - 1);
    localparam logic [TW-1:0] FILL_LOAD = TW'(MAX_ON_CYC - 1);

    pump_state_t   state_r;
    pump_state_t   next_s;
    logic          conflict_r;
    logic          conflict_s;
    logic [1:0]    code_r;
    logic [1:0]    code_next_s;
    logic [7:0]    fills_r;
    logic          fill_done_s;
    logic          moton_r;
    logic          fault_r;
    logic          load_s;
    logic [TW-1:0] load_val_s;
    logic          timer_en_s;
    logic          expired_s;

    pump_timer #(.WIDTH(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load_s),
        .en       (timer_en_s),
        .load_val (load_val_s),
        .expired  (expired_s)
    );

    assign timer_en_s = (state_r == REST) || (state_r == FILL);

    // Next-state, timer-load and fault-code decode in priority order.
    always_comb begin
        next_s      = state_r;
        code_next_s = code_r;
        load_s      = 1'b0;
        load_val_s  = REST_LOAD;
        fill_done_s = 1'b0;
        conflict_s  = conflict_r && bus.lowll && bus.highll &&
                      (state_r != IDLE) && (state_r != FAULT);
        if (conflict_s) begin
            next_s      = FAULT;
            code_next_s = FLT_CONFLICT;
        end else if (!bus.ennt && ((state_r == REST) || (state_r == ARMED) || (state_r == FILL))) begin
            next_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.ennt) begin
                        next_s = REST;
                        load_s = 1'b1;
                    end else begin
                        next_s = IDLE;
                    end
                end
                REST: begin
                    if (expired_s && bus.lowll) begin
                        next_s     = FILL;
                        load_s     = 1'b1;
                        load_val_s = FILL_LOAD;
                    end else if (expired_s) begin
                        next_s = ARMED;
                    end else begin
                        next_s = REST;
                    end
                end
                ARMED: begin
                    if (bus.lowll) begin
                        next_s     = FILL;
                        load_s     = 1'b1;
                        load_val_s = FILL_LOAD;
                    end else begin
                        next_s = ARMED;
                    end
                end
                FILL: begin
                    // High level beats a simultaneous timeout.
                    if (bus.highll) begin
                        next_s      = REST;
                        load_s      = 1'b1;
                        fill_done_s = 1'b1;
                    end else if (expired_s) begin
                        next_s      = FAULT;
                        code_next_s = FLT_DRYRUN;
                    end else begin
                        next_s = FILL;
                    end
                end
                FAULT: begin
                    if (bus.fault_clr && bus.ennt) begin
                        next_s      = REST;
                        load_s      = 1'b1;
                        code_next_s = FLT_NONE;
                    end else if (bus.fault_clr) begin
                        next_s      = IDLE;
                        code_next_s = FLT_NONE;
                    end else begin
                        next_s = FAULT;
                    end
                end
                default: begin
                    next_s = IDLE;
                end
            endcase
        end
    end

    // State, conflict history, fault code, fill counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            conflict_r <= 1'b0;
            code_r     <= FLT_NONE;
            fills_r    <= 8'd0;
            moton_r    <= 1'b0;
            fault_r    <= 1'b0;
        end else begin
            state_r    <= next_s;
            conflict_r <= bus.lowll & bus.highll;
            code_r     <= code_next_s;
            fills_r    <= fill_done_s ? sat_inc8(fills_r) : fills_r;
            moton_r    <= (next_s == FILL);
            fault_r    <= (next_s == FAULT);
        end
    end

    assign bus.moton      = moton_r;
    assign bus.fault      = fault_r;
    assign bus.fault_code = code_r;
    assign bus.fills_done = fills_r;

endmodule
